// File: rtl/stage4_mem_if.sv
// Bundle of the memory stage's pipeline, flush, memory-response and forwarding signals.
// The slave side is the stage itself; the master side drives and observes it.
interface stage4_mem_if #(parameter int PASS_W = 128);
  logic              wb_ex;
  logic              ertn_flush;
  logic              ws_allow_in;
  logic              ms_allow_in;
  logic              es_to_ms_valid;
  logic [31:0]       es_pc;
  logic              es_gr_we;
  logic [4:0]        es_dest;
  logic              es_res_from_mem;
  logic              es_mem_we;
  logic [4:0]        es_ld_op;
  logic [31:0]       es_result;
  logic              es_ex;
  logic [PASS_W-1:0] es_side;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic              ms_gr_we;
  logic [4:0]        ms_dest;
  logic [31:0]       ms_final_result;
  logic              ms_ex;
  logic [PASS_W-1:0] ms_side;
  logic              ms_has_ex;
  logic              ms_fwd_valid;
  logic [4:0]        ms_fwd_dest;
  logic [31:0]       ms_fwd_data;
  logic              ms_fwd_stall;
  logic              dbg_data_seen;
  logic              dbg_discard;

  modport slave (
    input  wb_ex, ertn_flush, ws_allow_in, es_to_ms_valid, es_pc, es_gr_we, es_dest,
           es_res_from_mem, es_mem_we, es_ld_op, es_result, es_ex, es_side,
           data_sram_data_ok, data_sram_rdata,
    output ms_allow_in, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result, ms_ex,
           ms_side, ms_has_ex, ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_stall,
           dbg_data_seen, dbg_discard
  );

  modport master (
    output wb_ex, ertn_flush, ws_allow_in, es_to_ms_valid, es_pc, es_gr_we, es_dest,
           es_res_from_mem, es_mem_we, es_ld_op, es_result, es_ex, es_side,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allow_in, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result, ms_ex,
           ms_side, ms_has_ex, ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_stall,
           dbg_data_seen, dbg_discard
  );
endinterface

// File: rtl/stage4_mem.sv
// Memory-access stage: waits for the data response of an issued load/store, extends
// load data, forwards to decode and drops a stale response left behind by a flush.
module stage4_mem #(
  parameter int PASS_W = 128
) (
  input logic         clk,
  input logic         reset,
  stage4_mem_if.slave bus
);
  // Handshakes: a transfer happens on a cycle where valid and the receiver's allow_in are
  // both high; valid never depends combinationally on the receiver's allow_in.
  logic              ms_valid;
  logic [31:0]       ms_pc;
  logic              ms_gr_we;
  logic [4:0]        ms_dest;
  logic              ms_res_from_mem;
  logic              ms_mem_we;
  logic [4:0]        ms_ld_op;
  logic [31:0]       ms_result;
  logic              ms_ex;
  logic [PASS_W-1:0] ms_side;
  logic [31:0]       rdata_buf;
  logic              data_seen;
  logic              discard;

  logic        flush, mem_op, data_ok_live, ready_go, allow_in;
  logic        accept, leave, capture, set_discard;
  logic [31:0] load_word, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign flush        = bus.wb_ex | bus.ertn_flush;
  assign mem_op       = ms_res_from_mem | ms_mem_we;
  assign data_ok_live = bus.data_sram_data_ok & ~discard;
  assign ready_go     = ~mem_op | ms_ex | data_seen | data_ok_live;
  assign allow_in     = ~discard & (~ms_valid | (ready_go & bus.ws_allow_in));
  assign accept       = bus.es_to_ms_valid & allow_in & ~flush;
  assign leave        = ms_valid & ready_go & bus.ws_allow_in;
  assign capture      = data_ok_live & ms_valid & mem_op & ~ms_ex & ~data_seen;
  // A request still in flight at flush time leaves one response to swallow later.
  assign set_discard  = flush & ms_valid & mem_op & ~ms_ex & ~data_seen & ~bus.data_sram_data_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      data_seen <= 1'b0;
      discard   <= 1'b0;
      rdata_buf <= 32'd0;
    end else begin
      if (flush)       ms_valid <= 1'b0;
      else if (accept) ms_valid <= 1'b1;
      else if (leave)  ms_valid <= 1'b0;

      if (accept || flush || leave) data_seen <= 1'b0;
      else if (capture)             data_seen <= 1'b1;

      if (capture) rdata_buf <= bus.data_sram_rdata;

      if (set_discard)                            discard <= 1'b1;
      else if (bus.data_sram_data_ok && discard)  discard <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_pc           <= 32'd0;
      ms_gr_we        <= 1'b0;
      ms_dest         <= 5'd0;
      ms_res_from_mem <= 1'b0;
      ms_mem_we       <= 1'b0;
      ms_ld_op        <= 5'd0;
      ms_result       <= 32'd0;
      ms_ex           <= 1'b0;
      ms_side         <= '0;
    end else if (accept) begin
      ms_pc           <= bus.es_pc;
      ms_gr_we        <= bus.es_gr_we & ~bus.es_ex;
      ms_dest         <= bus.es_dest;
      ms_res_from_mem <= bus.es_res_from_mem;
      ms_mem_we       <= bus.es_mem_we;
      ms_ld_op        <= bus.es_ld_op;
      ms_result       <= bus.es_result;
      ms_ex           <= bus.es_ex;
      ms_side         <= bus.es_side;
    end
  end

  // Data arriving this cycle is used directly; a response held over a stall comes from the buffer.
  assign load_word = data_seen ? rdata_buf : bus.data_sram_rdata;

  always_comb begin
    ld_byte = load_word[7:0];
    case (ms_result[1:0])
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      2'd3:    ld_byte = load_word[31:24];
      default: ld_byte = load_word[7:0];
    endcase
    ld_half  = ms_result[1] ? load_word[31:16] : load_word[15:0];
    load_ext = load_word;
    if (ms_ld_op[1])      load_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (ms_ld_op[2]) load_ext = {24'd0, ld_byte};
    else if (ms_ld_op[3]) load_ext = {{16{ld_half[15]}}, ld_half};
    else if (ms_ld_op[4]) load_ext = {16'd0, ld_half};
  end

  assign bus.ms_allow_in     = allow_in;
  assign bus.ms_to_ws_valid  = ms_valid & ready_go & ~flush;
  assign bus.ms_pc           = ms_pc;
  assign bus.ms_gr_we        = ms_gr_we;
  assign bus.ms_dest         = ms_dest;
  assign bus.ms_final_result = ms_res_from_mem ? load_ext : ms_result;
  assign bus.ms_ex           = ms_ex;
  assign bus.ms_side         = ms_side;
  assign bus.ms_has_ex       = ms_valid & ms_ex;
  assign bus.ms_fwd_valid    = ms_valid & ms_gr_we & (ms_dest != 5'd0);
  assign bus.ms_fwd_dest     = ms_dest;
  assign bus.ms_fwd_data     = bus.ms_final_result;
  assign bus.ms_fwd_stall    = bus.ms_fwd_valid & ms_res_from_mem & ~ready_go;
  assign bus.dbg_data_seen   = data_seen;
  assign bus.dbg_discard     = discard;
endmodule

// File: tb/tb_stage4_mem.sv
// Self-checking bench for stage4_mem: directed scenarios plus randomized loads/stores
// checked against a byte/half extraction model.
module tb_stage4_mem;
  localparam int PASS_W = 128;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   pending = 0;
  logic [PASS_W-1:0] drv_side;

  stage4_mem_if #(.PASS_W(PASS_W)) bus ();
  stage4_mem #(.PASS_W(PASS_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Responses may only be returned for requests the bench issued.
  always @(posedge clk)
    if (!reset && bus.data_sram_data_ok)
      assert (pending > 0) else $error("data_ok with no outstanding request");

  function automatic logic [31:0] load_model(input int op, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hff;
    h = (w >> (16 * a[1])) & 32'hffff;
    case (op)
      0: return w;
      1: return (b >= 128) ? b - 32'd256 : b;
      2: return b;
      3: return (h >= 32768) ? h - 32'd65536 : h;
      4: return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.es_to_ms_valid    = 1'b0;
    bus.es_pc             = 32'd0;
    bus.es_gr_we          = 1'b0;
    bus.es_dest           = 5'd0;
    bus.es_res_from_mem   = 1'b0;
    bus.es_mem_we         = 1'b0;
    bus.es_ld_op          = 5'd0;
    bus.es_result         = 32'd0;
    bus.es_ex             = 1'b0;
    bus.es_side           = '0;
    bus.data_sram_data_ok = 1'b0;
    bus.wb_ex             = 1'b0;
    bus.ertn_flush        = 1'b0;
    bus.ws_allow_in       = 1'b1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                       input logic gr_we, input logic rfm, input logic mwe,
                       input logic [4:0] ld_op, input logic ex);
    drv_side = {$urandom, $urandom, $urandom, $urandom};
    bus.es_to_ms_valid  = 1'b1;
    bus.es_pc           = pc;
    bus.es_result       = res;
    bus.es_dest         = dest;
    bus.es_gr_we        = gr_we;
    bus.es_res_from_mem = rfm;
    bus.es_mem_we       = mwe;
    bus.es_ld_op        = ld_op;
    bus.es_ex           = ex;
    bus.es_side         = drv_side;
    if ((rfm || mwe) && !ex) pending++;
  endtask

  task automatic test_reset();
    checks++; if (bus.ms_allow_in !== 1'b1) begin failures++; $display("FAIL rst_allow_in got=%0b exp=1", bus.ms_allow_in); end
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", bus.ms_to_ws_valid); end
    checks++; if (bus.ms_has_ex !== 1'b0) begin failures++; $display("FAIL rst_has_ex got=%0b exp=0", bus.ms_has_ex); end
    checks++; if ({bus.ms_fwd_valid, bus.ms_fwd_stall, bus.ms_fwd_dest, bus.ms_fwd_data} !== 39'd0) begin
      failures++; $display("FAIL rst_fwd got=%0b/%0b/%0d/%h exp=0", bus.ms_fwd_valid, bus.ms_fwd_stall, bus.ms_fwd_dest, bus.ms_fwd_data); end
    // Reset arriving while a load waits for its data.
    offer(32'h1c00_0000, 32'h0000_1000, 5'd4, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b0);
    step(); idle(); settle();
    checks++; if (bus.ms_allow_in !== 1'b0) begin failures++; $display("FAIL rst_wait_allow got=%0b exp=0", bus.ms_allow_in); end
    #2; reset = 1'b1; #1;
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.ms_to_ws_valid); end
    checks++; if (bus.ms_allow_in !== 1'b1) begin failures++; $display("FAIL rst_mid_allow got=%0b exp=1", bus.ms_allow_in); end
    checks++; if (bus.dbg_discard !== 1'b0) begin failures++; $display("FAIL rst_mid_discard got=%0b exp=0", bus.dbg_discard); end
    step(); reset = 1'b0; pending = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] p_res, p_pc, res, pc;
    logic [4:0]  p_dest, dest;
    logic [PASS_W-1:0] p_side;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        res  = (i == 0) ? 32'h1234_5678 : $urandom;
        pc   = $urandom;
        dest = (i == 3) ? 5'd0 : 5'($urandom_range(1, 31));
        offer(pc, res, dest, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      end else idle();
      settle();
      if (i > 0) begin
        checks++; if (bus.ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL alu_valid[%0d] got=%0b exp=1", i, bus.ms_to_ws_valid); end
        checks++; if (bus.ms_final_result !== p_res) begin failures++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, bus.ms_final_result, p_res); end
        checks++; if (bus.ms_pc !== p_pc || bus.ms_side !== p_side) begin failures++; $display("FAIL alu_pc_side[%0d] got=%h exp=%h", i, bus.ms_pc, p_pc); end
        checks++; if (bus.ms_fwd_valid !== (p_dest != 5'd0) || bus.ms_fwd_stall !== 1'b0) begin
          failures++; $display("FAIL alu_fwd[%0d] got=%0b/%0b exp=%0b/0", i, bus.ms_fwd_valid, bus.ms_fwd_stall, p_dest != 5'd0); end
        checks++; if (bus.ms_fwd_data !== p_res || bus.ms_fwd_dest !== p_dest) begin
          failures++; $display("FAIL alu_fwd_data[%0d] got=%h/%0d exp=%h/%0d", i, bus.ms_fwd_data, bus.ms_fwd_dest, p_res, p_dest); end
      end
      checks++; if (bus.ms_allow_in !== 1'b1) begin failures++; $display("FAIL alu_allow[%0d] got=%0b exp=1", i, bus.ms_allow_in); end
      p_res = res; p_pc = pc; p_dest = dest; p_side = drv_side;
      step();
    end
    settle();
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got=%0b exp=0", bus.ms_to_ws_valid); end
  endtask

  // op 0..4 = ld.w/ld.b/ld.bu/ld.h/ld.hu, op 5 = store.
  task automatic test_mem_case(input int op, input logic [31:0] addr, input logic [31:0] word,
                               input int delay, input int stall);
    logic        store;
    logic [31:0] exp;
    int          transfers;
    store = (op == 5);
    exp = store ? addr : load_model(op, addr[1:0], word);
    transfers = 0;
    offer($urandom, addr, 5'd7, ~store, ~store, store, store ? 5'd0 : 5'(1 << op), 1'b0);
    step(); idle();
    for (int k = 0; k < delay; k++) begin
      settle();
      if (bus.ms_to_ws_valid && bus.ws_allow_in) transfers++;
      checks++; if (bus.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL mem_wait_valid op=%0d got=%0b exp=0", op, bus.ms_to_ws_valid); end
      checks++; if (bus.ms_fwd_stall !== ~store) begin failures++; $display("FAIL mem_fwd_stall op=%0d got=%0b exp=%0b", op, bus.ms_fwd_stall, ~store); end
      step();
    end
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = word;
    bus.ws_allow_in       = (stall == 0);
    settle();
    if (bus.ms_to_ws_valid && bus.ws_allow_in) transfers++;
    checks++; if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_final_result !== exp) begin
      failures++; $display("FAIL mem_data_ok op=%0d addr=%h got=%0b/%h exp=1/%h", op, addr, bus.ms_to_ws_valid, bus.ms_final_result, exp); end
    checks++; if (bus.ms_fwd_stall !== 1'b0 || bus.ms_gr_we !== ~store) begin
      failures++; $display("FAIL mem_fwd op=%0d got=%0b/%0b exp=0/%0b", op, bus.ms_fwd_stall, bus.ms_gr_we, ~store); end
    step();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = $urandom;
    pending--;
    for (int j = 0; j < stall; j++) begin
      bus.ws_allow_in = (j == stall - 1);
      settle();
      if (bus.ms_to_ws_valid && bus.ws_allow_in) transfers++;
      checks++; if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_final_result !== exp || bus.dbg_data_seen !== 1'b1) begin
        failures++; $display("FAIL mem_buffered op=%0d got=%0b/%h/%0b exp=1/%h/1", op, bus.ms_to_ws_valid, bus.ms_final_result, bus.dbg_data_seen, exp); end
      step();
    end
    bus.ws_allow_in = 1'b1;
    settle();
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || transfers != 1) begin
      failures++; $display("FAIL mem_single_exit op=%0d got=%0b/%0d exp=0/1", op, bus.ms_to_ws_valid, transfers); end
  endtask

  task automatic test_random_mem();
    int op;
    logic [31:0] addr;
    for (int n = 0; n < 16; n++) begin
      op = $urandom_range(0, 5);
      addr = $urandom;
      if (op == 0 || op == 5) addr[1:0] = 2'b00;
      if (op == 3 || op == 4) addr[0] = 1'b0;
      test_mem_case(op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_flush_discard();
    offer(32'h1c00_0100, 32'h0000_2000, 5'd9, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b0);
    step(); idle(); step();
    bus.wb_ex = 1'b1;
    settle();
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0b exp=0", bus.ms_to_ws_valid); end
    step(); bus.wb_ex = 1'b0; settle();
    checks++; if (bus.ms_allow_in !== 1'b0 || bus.dbg_discard !== 1'b1) begin
      failures++; $display("FAIL fl_block got=%0b/%0b exp=0/1", bus.ms_allow_in, bus.dbg_discard); end
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_fwd_valid !== 1'b0) begin
      failures++; $display("FAIL fl_gone got=%0b/%0b exp=0/0", bus.ms_to_ws_valid, bus.ms_fwd_valid); end
    step();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h0000_DEAD;
    settle();
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allow_in !== 1'b0) begin
      failures++; $display("FAIL fl_stale got=%0b/%0b exp=0/0", bus.ms_to_ws_valid, bus.ms_allow_in); end
    step(); bus.data_sram_data_ok = 1'b0; pending--; settle();
    checks++; if (bus.ms_allow_in !== 1'b1 || bus.dbg_discard !== 1'b0) begin
      failures++; $display("FAIL fl_reopen got=%0b/%0b exp=1/0", bus.ms_allow_in, bus.dbg_discard); end
    test_mem_case(0, 32'h0000_3000, 32'h0000_CAFE, 1, 0);
  endtask

  task automatic test_flush_overrides_accept();
    offer(32'h1c00_0200, 32'h5555_AAAA, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.ertn_flush = 1'b1;
    step(); idle(); settle();
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_fwd_valid !== 1'b0) begin
      failures++; $display("FAIL ovr_accept got=%0b/%0b exp=0/0", bus.ms_to_ws_valid, bus.ms_fwd_valid); end
  endtask

  task automatic test_ex();
    offer(32'h1c00_0300, 32'h0000_4001, 5'd6, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1);
    step(); idle(); settle();
    checks++; if (bus.ms_has_ex !== 1'b1 || bus.ms_ex !== 1'b1) begin
      failures++; $display("FAIL ex_flag got=%0b/%0b exp=1/1", bus.ms_has_ex, bus.ms_ex); end
    checks++; if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_gr_we !== 1'b0 || bus.ms_fwd_valid !== 1'b0) begin
      failures++; $display("FAIL ex_pass got=%0b/%0b/%0b exp=1/0/0", bus.ms_to_ws_valid, bus.ms_gr_we, bus.ms_fwd_valid); end
    step(); settle();
    checks++; if (bus.ms_has_ex !== 1'b0 || bus.ms_to_ws_valid !== 1'b0) begin
      failures++; $display("FAIL ex_leave got=%0b/%0b exp=0/0", bus.ms_has_ex, bus.ms_to_ws_valid); end
  endtask

  task automatic test_flush_with_data_ok();
    offer(32'h1c00_0400, 32'h0000_5000, 5'd8, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b0);
    step(); idle();
    bus.wb_ex = 1'b1; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = $urandom;
    settle();
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL fdo_valid got=%0b exp=0", bus.ms_to_ws_valid); end
    step(); idle(); pending--; settle();
    checks++; if (bus.dbg_discard !== 1'b0 || bus.ms_allow_in !== 1'b1) begin
      failures++; $display("FAIL fdo_discard got=%0b/%0b exp=0/1", bus.dbg_discard, bus.ms_allow_in); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.data_sram_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    test_reset();
    test_back_to_back();
    test_mem_case(1, 32'h0000_1003, 32'h80FF_0000, 2, 0);
    test_mem_case(2, 32'h0000_1003, 32'h80FF_0000, 2, 0);
    test_mem_case(3, 32'h0000_1002, 32'hBEEF_1234, 1, 3);
    test_random_mem();
    test_flush_discard();
    test_flush_overrides_accept();
    test_ex();
    test_flush_with_data_ok();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stage4_mem.md
Name: stage4_mem

Overview:
- Memory-access pipeline stage of the 5-stage LoongArch core; sits between the execute stage and the write-back stage.
- Accepts one instruction per handshake from execute.
- For loads and stores whose request was already accepted by the memory interface (addr_ok in execute), waits for data_ok, captures rdata, and sign/zero-extends load data.
- Forwards the result to decode, drops in-flight responses on pipeline flush, and hands the final result to write-back.

Parameters:
PASS_W, 128, width of opaque sideband (CSR/exception fields), registered and forwarded to write-back unchanged.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wb_ex  in  1  exception flush from write-back
ertn_flush  in  1  ertn flush from write-back
ws_allow_in  in  1  write-back can accept
ms_allow_in  out  1  stage can accept from execute
es_to_ms_valid  in  1  execute offers an instruction
es_pc  in  32  instruction PC
es_gr_we  in  1  writes a GPR
es_dest  in  5  destination GPR
es_res_from_mem  in  1  load
es_mem_we  in  1  store
es_ld_op  in  5  one-hot: [0] ld.w, [1] ld.b, [2] ld.bu, [3] ld.h, [4] ld.hu
es_result  in  32  ALU/MUL/DIV result, or address for memory operations
es_ex  in  1  instruction carries an exception or ertn (no memory request issued)
es_side  in  PASS_W  sideband
data_sram_data_ok  in  1  memory response pulse
data_sram_rdata  in  32  response data
ms_to_ws_valid  out  1  valid to write-back
ms_pc  out  32  PC
ms_gr_we  out  1  es_gr_we & ~es_ex, registered
ms_dest  out  5  destination
ms_final_result  out  32  load-extended data or es_result
ms_ex  out  1  registered es_ex
ms_side  out  PASS_W  registered sideband
ms_has_ex  out  1  ms_valid & ms_ex; execute uses it to suppress new requests
ms_fwd_valid  out  1  ms_valid & ms_gr_we & dest≠0
ms_fwd_dest  out  5  forwarding destination
ms_fwd_data  out  32  equals ms_final_result
ms_fwd_stall  out  1  ms_fwd_valid & load & data not yet available

Behaviour:
- Registers: ms_valid, payload registers, rdata_buf, data_seen, discard.
- Reset (asynchronous): ms_valid=0, data_seen=0, discard=0, all payload registers and rdata_buf=0.
  - After reset: ms_allow_in=1, ms_to_ws_valid=0, ms_has_ex=0, all forwarding outputs 0.
- Memory operation: mem_op = res_from_mem | mem_we.
- Ready-go: ms_ready_go = ~mem_op | ms_ex | data_seen | (data_ok & ~discard).
- Allow-in: ms_allow_in = ~discard & (~ms_valid | (ms_ready_go & ws_allow_in)).
- Valid out: ms_to_ws_valid = ms_valid & ms_ready_go & ~wb_ex & ~ertn_flush.
- Accept: on es_to_ms_valid & ms_allow_in, latch the payload, ms_valid<=1, data_seen<=0.
  - Otherwise, when the instruction leaves, ms_valid<=0.
- Latency:
  - Non-memory op or excepted op: one cycle in the stage when ws_allow_in=1.
  - Memory op: leaves in the cycle data_ok arrives (rdata used combinationally), or later from rdata_buf if write-back stalls.
- data_ok handling:
  - data_ok with discard=0 and ms_valid & mem_op & ~ms_ex & ~data_seen: rdata_buf<=rdata, data_seen<=1.
    - If the instruction leaves in the same cycle, data_seen clears instead.
  - data_ok with discard=1: discard<=0; the data is ignored and has no other effect.
  - data_ok with neither condition: protocol violation; ignored, flagged by bench assertion.
- Flush (wb_ex | ertn_flush):
  - ms_valid<=0 and nothing is accepted; flush overrides a simultaneous accept.
  - If ms_valid & mem_op & ~ms_ex & ~data_seen & ~data_ok at flush: discard<=1, and ms_allow_in holds 0 until the stale data_ok arrives. At most one stale response is ever outstanding.
  - If data_ok coincides with the flush, that response is consumed and discard stays 0.
- Load extension uses addr[1:0]=ms_result[1:0]; data word d = data_seen ? rdata_buf : data_sram_rdata.
  - ld.w: d.
  - ld.b / ld.bu: byte d[8*addr+7 : 8*addr], sign-/zero-extended.
  - ld.h / ld.hu: half d[16*addr[1]+15 : 16*addr[1]], sign-/zero-extended.
  - Misaligned loads never reach here without ms_ex set.
- ms_final_result: ms_res_from_mem ? extended data : ms_result.
  - While ms_fwd_stall=1, the value is don't-care.
- Stores: ms_final_result = ms_result; ms_gr_we=0 from decode.

Test Plan:
- Reset mid-load (ms_valid=1, awaiting data_ok) -> same cycle: ms_to_ws_valid=0, ms_allow_in=1, discard=0.
- add result 0x12345678, ws_allow_in=1 -> next cycle ms_to_ws_valid=1, final=0x12345678, fwd_valid=1, fwd_stall=0.
- ld.b addr 0x...3, data_ok 2 cycles after entry with rdata 0x80FF_0000 -> fwd_stall=1 for 2 cycles, then final=0xFFFF_FF80. Repeat with ld.bu -> 0x0000_0080.
- ld.h addr 0x...2, ws_allow_in=0 when data_ok arrives with rdata 0xBEEF_1234, raised 3 cycles later -> rdata_buf holds the word, final=0xFFFF_BEEF on exit, single ms_to_ws_valid pulse.
- Load pending, wb_ex pulse -> ms_valid=0, ms_allow_in=0. Next data_ok (0xDEAD) ignored, ms_allow_in=1 the following cycle. New ld.w then receives its own data 0xCAFE.
- es_ex=1 load entry -> no data_ok waited, ms_has_ex=1, ms_to_ws_valid next cycle with ms_gr_we=0. Flush coinciding with data_ok -> discard stays 0.
